// File: rtl/branch_hazard_ctrl_p.sv
// Control-hazard controller: owns the fetch PC, tracks in-flight decodes in a
// circular FIFO and redirects/flushes on taken PC-relative branches.
module branch_hazard_ctrl_p #(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     OFFSET_W   = 16,
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     FETCH2EXEC = 3,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              fetch_rdy,
  output logic [PC_W-1:0]                   pc,
  output logic                              pc_vld,
  input  logic                              dec_vld,
  input  logic                              dec_branch,
  input  logic [PC_W-1:0]                   dec_pc,
  input  logic [OFFSET_W-1:0]               dec_off,
  input  logic                              exe_done,
  input  logic                              exe_zero,
  output logic                              flush,
  output logic [$clog2(FETCH2EXEC+1)-1:0]   squash_cnt,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              empty,
  output logic                              err
);

  localparam int unsigned SQ_W  = $clog2(FETCH2EXEC + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic                ent_br  [DEPTH];
  logic [PC_W-1:0]     ent_pc  [DEPTH];
  logic [OFFSET_W-1:0] ent_off [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;

  logic            do_pop, do_push, taken, err_ev;
  logic [PC_W-1:0] off_ext, target;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign pc_vld = !full;

  // Head resolution and tracker handshake decode
  always_comb begin
    do_pop  = exe_done && !empty;
    taken   = do_pop && ent_br[rd_ptr] && exe_zero;
    do_push = dec_vld && (squash_cnt == '0) && (!full || do_pop) && !taken;
    err_ev  = (dec_vld && (squash_cnt == '0) && full && !do_pop) || (exe_done && empty);
    off_ext = PC_W'($signed(ent_off[rd_ptr]));
    target  = ent_pc[rd_ptr] + PC_W'(4) + (off_ext << 2);
  end

  // Entry storage needs no reset; validity is carried by the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_br[wr_ptr]  <= dec_branch;
      ent_pc[wr_ptr]  <= dec_pc;
      ent_off[wr_ptr] <= dec_off;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc         <= RESET_PC;
      flush      <= 1'b0;
      squash_cnt <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      err        <= 1'b0;
    end else begin
      err <= err | err_ev;
      if (taken) begin
        pc         <= target;
        flush      <= 1'b1;
        squash_cnt <= SQ_W'(FETCH2EXEC);
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        flush <= 1'b0;
        if (fetch_rdy && pc_vld) pc <= pc + PC_W'(4);
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        // Wrong-path decodes are consumed one per dec_vld cycle
        if (dec_vld && (squash_cnt != '0)) squash_cnt <= squash_cnt - SQ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl_p.sv
// Directed plus randomized bench for branch_hazard_ctrl_p, checked against a
// queue-based reference model of the tracker, PC and squash rules.
module tb_branch_hazard_ctrl_p;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned F2E   = 3;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        fetch_rdy = 0, dec_vld = 0, dec_branch = 0, exe_done = 0, exe_zero = 0;
  logic [31:0] dec_pc = '0;
  logic [15:0] dec_off = '0;
  logic [31:0] pc;
  logic        pc_vld, flush, full, empty, err;
  logic [1:0]  squash_cnt;
  logic [2:0]  count;

  branch_hazard_ctrl_p #(.PC_W(32), .OFFSET_W(16), .DEPTH(DEPTH), .FETCH2EXEC(F2E),
                         .RESET_PC(32'h0)) dut (
    .clk(clk), .nrst(nrst), .fetch_rdy(fetch_rdy), .pc(pc), .pc_vld(pc_vld),
    .dec_vld(dec_vld), .dec_branch(dec_branch), .dec_pc(dec_pc), .dec_off(dec_off),
    .exe_done(exe_done), .exe_zero(exe_zero), .flush(flush), .squash_cnt(squash_cnt),
    .count(count), .full(full), .empty(empty), .err(err));

  always #5 clk = ~clk;

  typedef struct {
    bit        br;
    bit [31:0] pc;
    bit [15:0] off;
  } ent_t;

  ent_t      m_q[$];
  bit [31:0] m_pc;
  bit        m_flush, m_err;
  int        m_sq;
  int        checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("pc", 64'(pc), 64'(m_pc));
    check("pc_vld", 64'(pc_vld), 64'(m_q.size() != DEPTH));
    check("flush", 64'(flush), 64'(m_flush));
    check("squash_cnt", 64'(squash_cnt), 64'(m_sq));
    check("count", 64'(count), 64'(m_q.size()));
    check("full", 64'(full), 64'(m_q.size() == DEPTH));
    check("empty", 64'(empty), 64'(m_q.size() == 0));
    check("err", 64'(err), 64'(m_err));
  endtask

  task automatic m_reset();
    m_q.delete();
    m_pc = 32'h0; m_flush = 0; m_err = 0; m_sq = 0;
  endtask

  // One clock of model behaviour for the inputs applied this cycle
  task automatic m_step(input bit dv, db, input bit [31:0] dpc, input bit [15:0] doff,
                        input bit ed, ez, fr);
    int n    = m_q.size();
    bit fl   = (n == DEPTH);
    bit pop  = ed && n > 0;
    bit tk   = pop && m_q[0].br && ez;
    bit push = dv && m_sq == 0 && (!fl || pop) && !tk;
    if (ed && n == 0) m_err = 1;
    if (dv && m_sq == 0 && fl && !pop) m_err = 1;
    m_flush = tk;
    if (tk) begin
      int soff = int'(shortint'(m_q[0].off));
      m_pc = m_q[0].pc + 32'd4 + 32'(soff * 4);
      m_q.delete();
      m_sq = F2E;
    end else begin
      if (fr && !fl) m_pc = m_pc + 32'd4;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back('{db, dpc, doff});
      if (m_sq > 0 && dv) m_sq--;
    end
  endtask

  // Called at a falling edge: drive, advance model, check at the next falling edge
  task automatic cyc(input bit dv, db, input bit [31:0] dpc, input bit [15:0] doff,
                     input bit ed, ez, fr);
    dec_vld = dv; dec_branch = db; dec_pc = dpc; dec_off = doff;
    exe_done = ed; exe_zero = ez; fetch_rdy = fr;
    m_step(dv, db, dpc, doff, ed, ez, fr);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    nrst = 0;
    dec_vld = 0; dec_branch = 0; exe_done = 0; exe_zero = 0; fetch_rdy = 0;
    m_reset();
    #1 check_all();
    @(negedge clk);
    nrst = 1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Sequential fetch only
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    check("seq_pc16", 64'(pc), 64'h10);

    // Fill the tracker; pc must hold once full, overflow sets err
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h40 + 32'(4 * i), 0, 0, 0, 1);
    check("full_set", 64'(full), 64'h1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("pc_hold_full", 64'(pc), 64'h20);
    cyc(1, 0, 32'h50, 0, 0, 0, 0);
    check("overflow_err", 64'(err), 64'h1);
    cyc(1, 0, 32'h54, 0, 1, 0, 0);
    check("pushpop_full", 64'(count), 64'h4);

    // Taken branch at 0x100 off +3
    do_reset();
    cyc(1, 1, 32'h100, 16'h0003, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 1);
    check("tk_flush", 64'(flush), 64'h1);
    check("tk_pc", 64'(pc), 64'h110);
    check("tk_squash", 64'(squash_cnt), 64'h3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("flush_one_cycle", 64'(flush), 64'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h200, 0, 0, 0, 0);
    check("squash_done", 64'(squash_cnt), 64'h0);
    check("squash_nopush", 64'(count), 64'h0);
    cyc(1, 0, 32'h204, 0, 0, 0, 0);
    check("post_squash_push", 64'(count), 64'h1);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Negative offset, then not-taken
    cyc(1, 1, 32'h100, 16'hFFFE, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("neg_off_pc", 64'(pc), 64'hFC);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h100, 16'hFFFE, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("nt_noflush", 64'(flush), 64'h0);
    check("nt_seq_pc", 64'(pc), 64'h100);

    // Wrap-around of target and of sequential fetch; redirect beats fetch_rdy
    cyc(1, 1, 32'hFFFFFFF8, 16'h0002, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 1);
    check("wrap_target", 64'(pc), 64'h4);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hFFFFFFF0, 16'h0002, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("wrap_pre", 64'(pc), 64'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("wrap_seq", 64'(pc), 64'h0);

    // exe_done on empty, then reset mid-squash
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("empty_pop_err", 64'(err), 64'h1);
    cyc(1, 1, 32'h300, 16'h0010, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("mid_squash", 64'(squash_cnt), 64'h2);
    do_reset();
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_squash", 64'(squash_cnt), 64'h0);
    check("rst_err", 64'(err), 64'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 35,
               {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
               ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15) - 8),
               $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl_p.md
Name: branch_hazard_ctrl_p

Overview:
- Parametrised control-hazard controller for the MIPS pipeline.
- Owns the fetch PC and tracks in-flight decoded instructions in a DEPTH-entry ordered tracker.
- Resolves conditional branches when they leave execute. On a taken branch it redirects the PC to a PC-relative target, flushes the pipeline, and discards a fixed number of wrong-path decodes.
- Generalises the single-bit branch tracker to configurable PC width, tracker depth, offset width and squash depth, and adds stall, occupancy and error reporting.

Parameters:
- PC_W, 32, width of PC and target arithmetic.
- OFFSET_W, 16, width of branch immediate offset (sign-extended).
- DEPTH, 4, tracker entries; power of two, >=2.
- FETCH2EXEC, 3, wrong-path decoded instructions discarded after a redirect; 1..DEPTH.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- fetch_rdy  in  1  fetch consumes pc this cycle.
- pc  out  PC_W  current fetch PC.
- pc_vld  out  1  pc may be consumed; low while tracker full.
- dec_vld  in  1  decoded instruction pushes an entry.
- dec_branch  in  1  entry is a conditional branch.
- dec_pc  in  PC_W  PC of decoded instruction.
- dec_off  in  OFFSET_W  branch word offset.
- exe_done  in  1  oldest entry leaves execute (pop).
- exe_zero  in  1  branch condition true; sampled only with exe_done.
- flush  out  1  one-cycle pulse: pipeline redirect.
- squash_cnt  out  clog2(FETCH2EXEC+1)  remaining decodes to discard.
- count  out  clog2(DEPTH+1)  tracker occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (nrst low, async):
  - pc=RESET_PC, flush=0, squash_cnt=0, count=0, empty=1, full=0, err=0.
  - Tracker pointers are zeroed.
  - Reset asserted mid-operation drops all entries and any pending redirect.
- Tracker:
  - Circular FIFO of {branch, pc, off}, with rd/wr pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - The head is visible combinationally.
- Push condition: dec_vld && squash_cnt==0 && (!full || pop).
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - dec_vld while full with no pop sets err; the entry is dropped.
- Pop condition: exe_done && !empty.
  - exe_done while empty sets err; no other effect.
- Taken branch: pop && head.branch && exe_zero.
  - Target = head.pc + 4 + (sext(head.off) << 2), truncated to PC_W; wrap-around is silent.
  - At the next edge: pc<=target, flush<=1 for exactly one cycle, tracker cleared (count=0, pointers equal), squash_cnt<=FETCH2EXEC.
  - A push requested in the resolving cycle is dropped and does not count toward squash.
- Not-taken branch or non-branch pop: entry is removed, with no redirect.
- Sequential fetch: if no redirect and fetch_rdy && pc_vld, then pc<=pc+4 (mod 2^PC_W). A redirect has priority over fetch_rdy in the same cycle.
- pc_vld = !full (combinational from count).
- Squash:
  - While squash_cnt>0, each dec_vld cycle decrements squash_cnt by 1 and pushes nothing.
  - Cycles without dec_vld do not decrement.
  - A dec_vld asserted during the flush cycle counts toward squash.
- Simultaneous pop and push in a non-taken cycle: both occur; count unchanged.
- err: once set, it holds until reset.
- Latency:
  - Branch resolution to flush/pc update: 1 cycle.
  - Push to visible count: 1 cycle.
  - full, empty and count are registered-state-derived.

Test Plan:
- Reset then fetch_rdy held 4 cycles, no decode: pc goes 0,4,8,12,16; pc_vld=1; flush=0; count=0.
- Push 4 non-branch entries (DEPTH=4) with fetch_rdy high: full=1 and pc_vld=0, so pc holds. A 5th dec_vld with no pop sets err=1. Push+pop while full keeps count=4 with no err.
- Push a branch with dec_pc=0x100, dec_off=0x0003, then pop with exe_zero=1:
  - Next cycle flush=1 for one cycle, pc=0x110, count=0, squash_cnt=3.
  - Three dec_vld pulses are dropped and squash_cnt reaches 0; the 4th pulse pushes, count=1.
- Branch with dec_pc=0x100, dec_off=0xFFFE, taken: pc=0x0FC. Same branch with exe_zero=0: no flush, and pc continues sequentially.
- Wrap: PC_W=32, branch at 0xFFFFFFF8 with off=+2, taken: pc=0x00000004. Sequential fetch at 0xFFFFFFFC goes to 0x00000000.
- Taken branch and fetch_rdy in the same cycle: pc=target (not pc+4). exe_done on empty sets err=1. nrst pulse mid-squash gives pc=RESET_PC, squash_cnt=0, err=0.
